// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, FSM state
// encoding and the buffer-occupancy helper.
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int INSTR_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    // Occupancy after this cycle's push/pop; a push into a full buffer only
    // lands alongside a pop, so two bits never overflow.
    function automatic logic [1:0] occ_next(input logic [1:0] cnt,
                                            input logic       push,
                                            input logic       pop);
        return cnt + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer holding {instr, pc}; entry 0 is the head.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    input  logic [ADDR_WIDTH-1:0]  push_pc_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output logic [INSTR_WIDTH-1:0] head_instr_o,
    output logic [ADDR_WIDTH-1:0]  head_pc_o,
    output logic [1:0]             count_o
);

    logic [INSTR_WIDTH-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [ADDR_WIDTH-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
    logic [1:0]             count_q, count_d, count_mid_s;
    logic                   pop_s, push_s;

    // Next-state: pop shifts entry 1 forward, push fills the first free slot.
    always_comb begin
        instr0_d    = instr0_q;
        instr1_d    = instr1_q;
        pc0_d       = pc0_q;
        pc1_d       = pc1_q;
        count_d     = count_q;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        count_mid_s = count_q;
        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            pop_s       = pop_i && (count_q != 2'd0);
            push_s      = push_i && ((count_q != 2'd2) || pop_s);
            count_mid_s = count_q - {1'b0, pop_s};
            if (pop_s) begin
                instr0_d = instr1_q;
                pc0_d    = pc1_q;
            end else begin
                instr0_d = instr0_q;
            end
            if (push_s) begin
                if (count_mid_s == 2'd0) begin
                    instr0_d = push_instr_i;
                    pc0_d    = push_pc_i;
                end else begin
                    instr1_d = push_instr_i;
                    pc1_d    = push_pc_i;
                end
            end else begin
                instr1_d = instr1_q;
            end
            count_d = count_mid_s + {1'b0, push_s};
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            count_q  <= 2'd0;
        end else begin
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
            count_q  <= count_d;
        end
    end

    assign head_instr_o = (count_q != 2'd0) ? instr0_q : '0;
    assign head_pc_o    = (count_q != 2'd0) ? pc0_q : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential memory reads from the program
// counter, buffers up to two instructions and recovers from branch flushes.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic                   pc_step,
    input  logic                   flush,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  mem_req_q;
    logic [1:0]            count_s, occ_after_s;
    logic                  push_s, pop_s;

    assign push_s      = (state_q == S_REQ) && mem_ack && !flush;
    assign pop_s       = instr_valid && instr_ready;
    assign occ_after_s = occ_next(count_s, push_s, pop_s);
    assign pc_step     = push_s;
    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign instr_valid = (count_s != 2'd0);

    // Fetch sequencing; mem_req is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            mem_req_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!flush) begin
                        addr_q    <= pc;
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        // A flush coinciding with the ack completes the read, so
                        // no drain is needed.
                        state_q   <= mem_ack ? S_IDLE : S_DRAIN;
                        mem_req_q <= !mem_ack;
                    end else if (mem_ack) begin
                        addr_q <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        if (occ_after_s == 2'd2) begin
                            state_q   <= S_WAIT;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else if (occ_after_s != 2'd2) begin
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_buffer #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_s),
        .push_instr_i (mem_rdata),
        .push_pc_i    (addr_q),
        .pop_i        (pop_s),
        .clear_i      (flush),
        .head_instr_o (instr),
        .head_pc_o    (instr_pc),
        .count_o      (count_s)
    );

endmodule
